// File: rtl/softmax_argmax_pkg.sv
// Shared definitions for the softmax argmax classifier: widths, FSM states
// and float classification helpers reused by the compare sub-module.
package softmax_argmax_pkg;

  localparam int MAX_FLOAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int data_width(input int ew, input int mw);
    return ew + mw + 1;
  endfunction

  function automatic int index_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Helpers take the float zero-extended to MAX_FLOAT_W so any format fits.
  function automatic logic is_nan(input logic [MAX_FLOAT_W-1:0] v,
                                  input int ew, input int mw);
    logic exp_ones;
    logic man_nz;
    exp_ones = 1'b1;
    man_nz   = 1'b0;
    for (int i = 0; i < MAX_FLOAT_W; i++) begin
      if (i < mw)           man_nz   = man_nz | v[i];
      else if (i < mw + ew) exp_ones = exp_ones & v[i];
    end
    return exp_ones & man_nz;
  endfunction

  function automatic logic is_zero(input logic [MAX_FLOAT_W-1:0] v,
                                   input int ew, input int mw);
    logic any;
    any = 1'b0;
    for (int i = 0; i < MAX_FLOAT_W; i++) begin
      if (i < mw + ew) any = any | v[i];
    end
    return ~any;
  endfunction

endpackage

// File: rtl/softmax_argmax_float_greater.sv
// Combinational strict a > b for IEEE-style floats; NaN never wins and
// signed zeros compare equal.
module float_greater
  import softmax_argmax_pkg::*;
#(
  parameter int  EXPONENT_WIDTH = 8,
  parameter int  MANTISSA_WIDTH = 23,
  localparam int DATA_WIDTH     = data_width(EXPONENT_WIDTH, MANTISSA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  gt
);

  logic [MAX_FLOAT_W-1:0] w_a_ext;
  logic [MAX_FLOAT_W-1:0] w_b_ext;
  logic                   w_a_nan;
  logic                   w_b_nan;
  logic                   w_both_zero;
  logic [DATA_WIDTH-2:0]  w_a_mag;
  logic [DATA_WIDTH-2:0]  w_b_mag;

  assign w_a_ext     = MAX_FLOAT_W'(a);
  assign w_b_ext     = MAX_FLOAT_W'(b);
  assign w_a_nan     = is_nan(w_a_ext, EXPONENT_WIDTH, MANTISSA_WIDTH);
  assign w_b_nan     = is_nan(w_b_ext, EXPONENT_WIDTH, MANTISSA_WIDTH);
  assign w_both_zero = is_zero(w_a_ext, EXPONENT_WIDTH, MANTISSA_WIDTH) &
                       is_zero(w_b_ext, EXPONENT_WIDTH, MANTISSA_WIDTH);
  assign w_a_mag     = a[DATA_WIDTH-2:0];
  assign w_b_mag     = b[DATA_WIDTH-2:0];

  always_comb begin
    // NOTE: gt gets a default before the decision chain so no path leaves it
    // unassigned, which would otherwise infer a latch.
    gt = 1'b0;
    if (w_a_nan)                           gt = 1'b0;
    else if (w_b_nan)                      gt = 1'b1;
    else if (w_both_zero)                  gt = 1'b0;
    else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) gt = ~a[DATA_WIDTH-1];
    else if (!a[DATA_WIDTH-1])             gt = (w_a_mag > w_b_mag);
    else                                   gt = (w_a_mag < w_b_mag);
  end

endmodule

// File: rtl/softmax_argmax.sv
// Argmax over the packed softmax output: captures the vector on start and
// scans one element per clock, keeping the lowest-index strict maximum.
module softmax_argmax
  import softmax_argmax_pkg::*;
#(
  parameter int  EXPONENT_WIDTH = 8,
  parameter int  MANTISSA_WIDTH = 23,
  parameter int  numberOfInputs = 10,
  parameter int  INDEX_WIDTH    = 4,
  localparam int DATA_WIDTH     = data_width(EXPONENT_WIDTH, MANTISSA_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [DATA_WIDTH*numberOfInputs-1:0] input_probs,
  input  logic                                 start,
  output logic [INDEX_WIDTH-1:0]               class_index,
  output logic [DATA_WIDTH-1:0]                max_value,
  output logic                                 done_argmax
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(numberOfInputs - 1);

  if (INDEX_WIDTH < index_width(numberOfInputs)) begin : g_bad_index_width
    $error("INDEX_WIDTH too small for numberOfInputs");
  end

  state_e                              r_state;
  logic [DATA_WIDTH*numberOfInputs-1:0] r_probs;
  logic [DATA_WIDTH-1:0]               r_best;
  logic [INDEX_WIDTH-1:0]              r_best_idx;
  logic [INDEX_WIDTH-1:0]              r_cnt;

  logic [DATA_WIDTH-1:0] w_elems [numberOfInputs];
  logic [DATA_WIDTH-1:0] w_elem;
  logic                  w_gt;
  logic [DATA_WIDTH-1:0] w_best_next;
  logic [INDEX_WIDTH-1:0] w_best_idx_next;

  always_comb begin
    for (int i = 0; i < numberOfInputs; i++) begin
      w_elems[i] = r_probs[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_elem = w_elems[r_cnt];

  float_greater #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .MANTISSA_WIDTH(MANTISSA_WIDTH)
  ) u_greater (
    .a (w_elem),
    .b (r_best),
    .gt(w_gt)
  );

  assign w_best_next     = w_gt ? w_elem : r_best;
  assign w_best_idx_next = w_gt ? r_cnt  : r_best_idx;

  // NOTE: the wide capture register is reset along with the control state so
  // an aborted scan leaves nothing stale behind; sequential state uses <= only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_probs     <= '0;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_cnt       <= '0;
      class_index <= '0;
      max_value   <= '0;
      done_argmax <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_probs    <= input_probs;
            r_best     <= input_probs[DATA_WIDTH-1:0];
            r_best_idx <= '0;
            if (numberOfInputs == 1) begin
              r_cnt       <= '0;
              r_state     <= ST_DONE;
              class_index <= '0;
              max_value   <= input_probs[DATA_WIDTH-1:0];
              done_argmax <= 1'b1;
            end else begin
              r_cnt   <= INDEX_WIDTH'(1);
              r_state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          r_best     <= w_best_next;
          r_best_idx <= w_best_idx_next;
          if (r_cnt == LAST_IDX) begin
            r_state     <= ST_DONE;
            class_index <= w_best_idx_next;
            max_value   <= w_best_next;
            done_argmax <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // Requiring start to drop first keeps a held done_softmax from retriggering.
          if (!start) begin
            r_state     <= ST_IDLE;
            done_argmax <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_argmax.sv
// Self-checking bench for softmax_argmax: directed plan cases plus random
// vectors scored against an order-key argmax model.
module tb_softmax_argmax;

  localparam int DW = 32;
  localparam int N  = 10;
  localparam int VW = DW * N;

  logic          clk;
  logic          reset_n;
  logic [VW-1:0] input_probs;
  logic          start;
  logic [3:0]    class_index;
  logic [DW-1:0] max_value;
  logic          done_argmax;

  int            n_checks;
  int            n_fail;
  int            exp_idx;
  logic [DW-1:0] exp_val;

  softmax_argmax dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .input_probs(input_probs),
    .start      (start),
    .class_index(class_index),
    .max_value  (max_value),
    .done_argmax(done_argmax)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout global bound reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic f_is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  // Monotone key: larger key means larger float; both zeros share one key.
  function automatic logic [31:0] f_key(input logic [31:0] f);
    if (f[30:0] == 31'd0) return 32'h8000_0000;
    if (f[31])            return ~f;
    return f | 32'h8000_0000;
  endfunction

  task automatic model(input logic [VW-1:0] vec);
    int            best;
    logic [31:0]   e;
    best = -1;
    for (int i = 0; i < N; i++) begin
      e = vec[i*DW +: DW];
      if (!f_is_nan(e)) begin
        if (best < 0) best = i;
        else if (f_key(e) > f_key(vec[best*DW +: DW])) best = i;
      end
    end
    if (best < 0) best = 0;
    exp_idx = best;
    exp_val = vec[best*DW +: DW];
  endtask

  function automatic logic [VW-1:0] fill(input logic [31:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [31:0] rand_elem();
    logic [31:0] t;
    t = $urandom();
    case ($urandom_range(0, 8))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return 32'h7FC0_0000 | (t & 32'h8000_000F);
      5: return 32'h3F80_0000;
      6: return t | 32'h8000_0000;
      7: return {1'b0, 8'h3F, t[22:0]};
      default: return t;
    endcase
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = rand_elem();
    return r;
  endfunction

  // Called at a negedge; returns at the negedge where done is first seen.
  task automatic run_scan(input logic [VW-1:0] vec, input string tag);
    int lat;
    model(vec);
    input_probs = vec;
    start       = 1'b1;
    lat         = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      input_probs = rand_vec();
    end while (!done_argmax && lat < 40);
    check({tag, "_latency"}, 64'(lat), 64'(N));
    check({tag, "_index"}, 64'(class_index), 64'(exp_idx));
    check({tag, "_value"}, 64'(max_value), 64'(exp_val));
  endtask

  task automatic drop_start(input string tag);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_low"}, 64'(done_argmax), 64'd0);
    check({tag, "_index_kept"}, 64'(class_index), 64'(exp_idx));
  endtask

  initial begin
    logic [VW-1:0] v;
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    input_probs = '0;

    repeat (2) @(negedge clk);
    check("reset_index", 64'(class_index), 64'd0);
    check("reset_value", 64'(max_value), 64'd0);
    check("reset_done", 64'(done_argmax), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_start_done", 64'(done_argmax), 64'd0);

    v = fill(32'h3DCC_CCCD);
    v[7*DW +: DW] = 32'h3F00_0000;
    run_scan(v, "ordinary");
    check("ordinary_index_const", 64'(class_index), 64'd7);
    check("ordinary_value_const", 64'(max_value), 64'h3F00_0000);
    drop_start("ordinary");

    v = fill(32'h3E00_0000);
    v[2*DW +: DW] = 32'h3F80_0000;
    v[8*DW +: DW] = 32'h3F80_0000;
    run_scan(v, "tie");
    check("tie_index_const", 64'(class_index), 64'd2);
    drop_start("tie");

    v = fill(32'hBF80_0000);
    v[4*DW +: DW] = 32'hBF00_0000;
    run_scan(v, "negative");
    check("negative_index_const", 64'(class_index), 64'd4);
    drop_start("negative");

    v = fill(32'hBF80_0000);
    v[0*DW +: DW] = 32'h8000_0000;
    v[1*DW +: DW] = 32'h0000_0000;
    run_scan(v, "zeros");
    check("zeros_index_const", 64'(class_index), 64'd0);
    drop_start("zeros");

    v = fill(32'h0000_0000);
    v[0*DW +: DW] = 32'h7FC0_0000;
    v[3*DW +: DW] = 32'h3F80_0000;
    run_scan(v, "nan");
    check("nan_index_const", 64'(class_index), 64'd3);
    check("nan_value_const", 64'(max_value), 64'h3F80_0000);
    drop_start("nan");

    v = fill(32'h7FC0_0001);
    v[6*DW +: DW] = 32'hFFC0_0000;
    run_scan(v, "all_nan");
    check("all_nan_index_const", 64'(class_index), 64'd0);
    drop_start("all_nan");

    v = fill(32'h7F7F_FFFF);
    v[5*DW +: DW] = 32'h7F80_0000;
    v[1*DW +: DW] = 32'h7FFF_FFFF;
    run_scan(v, "inf");
    drop_start("inf");

    for (int t = 0; t < 40; t++) begin
      run_scan(rand_vec(), $sformatf("rand%0d", t));
      drop_start($sformatf("rand%0d", t));
    end

    v = fill(32'h3F00_0000);
    v[1*DW +: DW] = 32'h3F40_0000;
    run_scan(v, "hold");
    for (int k = 0; k < 3; k++) begin
      input_probs = rand_vec();
      @(negedge clk);
      check("hold_done_high", 64'(done_argmax), 64'd1);
      check("hold_index", 64'(class_index), 64'(exp_idx));
      check("hold_value", 64'(max_value), 64'(exp_val));
    end
    drop_start("hold");
    v = fill(32'h3E00_0000);
    v[9*DW +: DW] = 32'h3F80_0000;
    run_scan(v, "retrigger");
    check("retrigger_index_const", 64'(class_index), 64'd9);
    drop_start("retrigger");

    v = fill(32'h3E00_0000);
    v[3*DW +: DW] = 32'h3F00_0000;
    input_probs = v;
    start       = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midscan_reset_index", 64'(class_index), 64'd0);
    check("midscan_reset_value", 64'(max_value), 64'd0);
    check("midscan_reset_done", 64'(done_argmax), 64'd0);
    v = fill(32'hBE00_0000);
    v[6*DW +: DW] = 32'h3C00_0000;
    input_probs = v;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midscan_reset_held_done", 64'(done_argmax), 64'd0);
    reset_n = 1'b1;
    run_scan(v, "recapture");
    check("recapture_index_const", 64'(class_index), 64'd6);
    drop_start("recapture");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
